// File: rtl/dma_usr_irq_flr_sched.sv
// ---------------------------------------------------------------------------
// dma_usr_irq_flr_sched
//
// Purpose:
//   Arbitrates user-interrupt set/clear requests from NUM_REQ requesters and
//   FLR-done notifications, then sequences them onto the DMA fabric input
//   port. That port has no backpressure. This block therefore issues at most
//   one single-cycle event at a time, and follows each event with GAP_CYCLES
//   quiet cycles.
//   FLR normally wins arbitration. After an FLR grant, pending interrupts win
//   the next slot, so the two paths alternate under contention. Interrupt
//   requesters are served round-robin.
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   en                         arbitration enable (blocks new grants only)
//   req_vld/set/vec/fnc        per-requester interrupt request and payload
//   req_rdy                    one-hot interrupt accept strobe (IDLE only)
//   flr_req_vld/fnc            FLR-done request and function
//   flr_req_rdy                FLR accept strobe (IDLE only)
//   usr_irq_set/clr/vec/fnc    fabric interrupt pulse and payload
//   flr_done_vld/fnc           fabric FLR-done pulse and function
//   busy                       high whenever not in IDLE
//   issued_cnt                 wrapping count of issued events
// ---------------------------------------------------------------------------
module dma_usr_irq_flr_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [NUM_REQ-1:0]   req_set,
    input  logic [NUM_REQ*5-1:0] req_vec,
    input  logic [NUM_REQ*8-1:0] req_fnc,
    output logic [NUM_REQ-1:0]   req_rdy,
    input  logic                 flr_req_vld,
    input  logic [7:0]           flr_req_fnc,
    output logic                 flr_req_rdy,
    output logic                 usr_irq_set,
    output logic                 usr_irq_clr,
    output logic [4:0]           usr_irq_vec,
    output logic [7:0]           usr_irq_fnc,
    output logic                 flr_done_vld,
    output logic [7:0]           flr_done_fnc,
    output logic                 busy,
    output logic [CNT_W-1:0]     issued_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               flr_last_q, flr_last_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               set_q, set_d, clr_q, clr_d, fd_vld_q, fd_vld_d;
    logic [4:0]         vec_q, vec_d;
    logic [7:0]         fnc_q, fnc_d, fd_fnc_q, fd_fnc_d;

    logic               can_grant, irq_any, irq_hit, flr_win;
    logic               grant_flr, grant_irq;
    logic [PTR_W-1:0]   irq_idx, idx_w;
    int                 idx;

    // Combinational arbitration. rst_n gates the strobes so that no accept
    // can be seen while the block is held in reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        irq_hit = 1'b0;
        irq_idx = '0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = PTR_W'(idx);
            if (!irq_hit && req_vld[idx_w]) begin
                irq_hit = 1'b1;
                irq_idx = idx_w;
            end
        end
        irq_any     = |req_vld;
        can_grant   = rst_n && en && (state_q == S_IDLE);
        flr_win     = flr_req_vld && !(flr_last_q && irq_any);
        grant_flr   = can_grant && flr_win;
        grant_irq   = can_grant && !flr_win && irq_hit;
        req_rdy     = grant_irq ? (NUM_REQ'(1) << irq_idx) : '0;
        flr_req_rdy = grant_flr;
    end

    // Next-state logic. The output registers default to zero, so every event
    // appears for exactly the one ISSUE cycle that follows its grant.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        flr_last_d = flr_last_q;
        gap_cnt_d  = gap_cnt_q;
        cnt_d      = cnt_q;
        set_d      = 1'b0;
        clr_d      = 1'b0;
        vec_d      = '0;
        fnc_d      = '0;
        fd_vld_d   = 1'b0;
        fd_fnc_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_flr) begin
                    fd_vld_d   = 1'b1;
                    fd_fnc_d   = flr_req_fnc;
                    flr_last_d = 1'b1;
                    state_d    = S_ISSUE;
                end else if (grant_irq) begin
                    set_d      = req_set[irq_idx];
                    clr_d      = !req_set[irq_idx];
                    vec_d      = req_vec[int'(irq_idx)*5 +: 5];
                    fnc_d      = req_fnc[int'(irq_idx)*8 +: 8];
                    flr_last_d = 1'b0;
                    rr_ptr_d   = (irq_idx == PTR_W'(NUM_REQ - 1)) ? '0 : irq_idx + PTR_W'(1);
                    state_d    = S_ISSUE;
                end
                // The count advances together with the pulse register, so it
                // already includes the event while that event is on the port.
                if (grant_flr || grant_irq) cnt_d = cnt_q + CNT_W'(1);
            end
            S_ISSUE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) state_d = S_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            flr_last_q <= 1'b0;
            gap_cnt_q  <= '0;
            cnt_q      <= '0;
            set_q      <= 1'b0;
            clr_q      <= 1'b0;
            vec_q      <= '0;
            fnc_q      <= '0;
            fd_vld_q   <= 1'b0;
            fd_fnc_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so that every
            // flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            flr_last_q <= flr_last_d;
            gap_cnt_q  <= gap_cnt_d;
            cnt_q      <= cnt_d;
            set_q      <= set_d;
            clr_q      <= clr_d;
            vec_q      <= vec_d;
            fnc_q      <= fnc_d;
            fd_vld_q   <= fd_vld_d;
            fd_fnc_q   <= fd_fnc_d;
        end
    end

    assign usr_irq_set  = set_q;
    assign usr_irq_clr  = clr_q;
    assign usr_irq_vec  = vec_q;
    assign usr_irq_fnc  = fnc_q;
    assign flr_done_vld = fd_vld_q;
    assign flr_done_fnc = fd_fnc_q;
    assign busy         = (state_q != S_IDLE);
    assign issued_cnt   = cnt_q;

endmodule

// File: tb/tb_dma_usr_irq_flr_sched.sv
// ---------------------------------------------------------------------------
// tb_dma_usr_irq_flr_sched
//
// Two instances share clk/rst_n:
//   dut 0: GAP_CYCLES=2, CNT_W=4  (main scenarios, counter wrap)
//   dut 1: GAP_CYCLES=0, CNT_W=16 (clear path, back-to-back issue)
// A slot-level reference model predicts, every cycle, the accept strobes,
// the pulse and payload on the fabric port, busy and the event count. It
// works from the grant time, the gap length and the priority/round-robin
// rules.
// ---------------------------------------------------------------------------
module tb_dma_usr_irq_flr_sched;

    localparam int N  = 4;
    localparam int OW = 46;
    localparam int FLR_ID = N;   // grant id used for the FLR path

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           en_s      [2];
    logic [N-1:0]   vld_s     [2];
    logic [N-1:0]   set_s     [2];
    logic [N*5-1:0] vec_s     [2];
    logic [N*8-1:0] fnc_s     [2];
    logic           flr_vld_s [2];
    logic [7:0]     flr_fnc_s [2];

    logic [N-1:0]   rdy_o     [2];
    logic           flr_rdy_o [2];
    logic           set_o     [2];
    logic           clr_o     [2];
    logic [4:0]     vec_o     [2];
    logic [7:0]     fnc_o     [2];
    logic           fdv_o     [2];
    logic [7:0]     fdf_o     [2];
    logic           busy_o    [2];
    logic [3:0]     cnt_a;
    logic [15:0]    cnt_b;

    dma_usr_irq_flr_sched #(.NUM_REQ(N), .GAP_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_s[0]),
        .req_vld(vld_s[0]), .req_set(set_s[0]), .req_vec(vec_s[0]), .req_fnc(fnc_s[0]),
        .req_rdy(rdy_o[0]),
        .flr_req_vld(flr_vld_s[0]), .flr_req_fnc(flr_fnc_s[0]), .flr_req_rdy(flr_rdy_o[0]),
        .usr_irq_set(set_o[0]), .usr_irq_clr(clr_o[0]), .usr_irq_vec(vec_o[0]), .usr_irq_fnc(fnc_o[0]),
        .flr_done_vld(fdv_o[0]), .flr_done_fnc(fdf_o[0]),
        .busy(busy_o[0]), .issued_cnt(cnt_a)
    );

    dma_usr_irq_flr_sched #(.NUM_REQ(N), .GAP_CYCLES(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_s[1]),
        .req_vld(vld_s[1]), .req_set(set_s[1]), .req_vec(vec_s[1]), .req_fnc(fnc_s[1]),
        .req_rdy(rdy_o[1]),
        .flr_req_vld(flr_vld_s[1]), .flr_req_fnc(flr_fnc_s[1]), .flr_req_rdy(flr_rdy_o[1]),
        .usr_irq_set(set_o[1]), .usr_irq_clr(clr_o[1]), .usr_irq_vec(vec_o[1]), .usr_irq_fnc(fnc_o[1]),
        .flr_done_vld(fdv_o[1]), .flr_done_fnc(fdf_o[1]),
        .busy(busy_o[1]), .issued_cnt(cnt_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state, per instance.
    int         m_free     [2];   // first cycle in which a grant is possible
    int         m_issue    [2];   // cycle carrying the pending pulse
    int         m_rr       [2];
    int         m_cnt      [2];
    bit         m_flr_last [2];
    bit         m_is_flr   [2];
    bit         m_set      [2];
    logic [4:0] m_vec      [2];
    logic [7:0] m_fnc      [2];
    int         g_who      [2];   // model grant this cycle (-1 none)
    int         o_who      [2];   // grant decoded from DUT strobes (-1 none, -2 illegal)

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int mask_of(input int d);
        return (d == 0) ? 32'hF : 32'hFFFF;
    endfunction

    function automatic logic [OW-1:0] obs(input int d);
        logic [15:0] c;
        c = (d == 0) ? {12'd0, cnt_a} : cnt_b;
        return {rdy_o[d], flr_rdy_o[d], set_o[d], clr_o[d], vec_o[d], fnc_o[d],
                fdv_o[d], fdf_o[d], busy_o[d], c};
    endfunction

    function automatic int decode_who(input int d);
        int w;
        int hits;
        w = -1;
        hits = 0;
        for (int i = 0; i < N; i++) if (rdy_o[d][i] === 1'b1) begin w = i; hits++; end
        if (flr_rdy_o[d] === 1'b1) begin w = FLR_ID; hits++; end
        return (hits > 1) ? -2 : w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_free[d] = 0; m_issue[d] = -1; m_rr[d] = 0; m_cnt[d] = 0;
            m_flr_last[d] = 1'b0; m_is_flr[d] = 1'b0; m_set[d] = 1'b0;
            m_vec[d] = '0; m_fnc[d] = '0; g_who[d] = -1; o_who[d] = -1;
        end
    endtask

    task automatic idle_inputs(input int d);
        en_s[d] = 1'b1; vld_s[d] = '0; set_s[d] = '0; vec_s[d] = '0; fnc_s[d] = '0;
        flr_vld_s[d] = 1'b0; flr_fnc_s[d] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // One clock cycle for instance d: inputs are already applied; predict,
    // compare, then advance the model and the clock to the next negedge.
    task automatic step(input int d);
        int         win;
        bit         pulse;
        logic [N-1:0] e_rdy;
        logic [OW-1:0] e, o;
        #1;
        pulse = (cyc == m_issue[d]);
        if (pulse) m_cnt[d] = (m_cnt[d] + 1) & mask_of(d);
        win = -1;
        if (cyc >= m_free[d] && en_s[d]) begin
            if (flr_vld_s[d] && !(m_flr_last[d] && (|vld_s[d]))) begin
                win = FLR_ID;
            end else begin
                for (int k = 0; k < N; k++)
                    if (win < 0 && vld_s[d][(m_rr[d] + k) % N]) win = (m_rr[d] + k) % N;
            end
        end
        e_rdy = '0;
        if (win >= 0 && win < N) e_rdy[win] = 1'b1;
        e = {e_rdy, 1'(win == FLR_ID),
             1'(pulse && !m_is_flr[d] && m_set[d]),
             1'(pulse && !m_is_flr[d] && !m_set[d]),
             (pulse && !m_is_flr[d]) ? m_vec[d] : 5'd0,
             (pulse && !m_is_flr[d]) ? m_fnc[d] : 8'd0,
             1'(pulse && m_is_flr[d]),
             (pulse && m_is_flr[d]) ? m_fnc[d] : 8'd0,
             1'(cyc >= m_issue[d] && cyc < m_free[d]),
             16'(m_cnt[d])};
        o = obs(d);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL cycle dut%0d cyc=%0d got=%h expected=%h", d, cyc, o, e);
        end
        o_who[d] = decode_who(d);
        g_who[d] = win;
        if (win >= 0) begin
            m_issue[d] = cyc + 1;
            m_free[d]  = cyc + gap_of(d) + 2;
            if (win == FLR_ID) begin
                m_is_flr[d] = 1'b1; m_fnc[d] = flr_fnc_s[d]; m_flr_last[d] = 1'b1;
            end else begin
                m_is_flr[d] = 1'b0; m_set[d] = set_s[d][win];
                m_vec[d] = vec_s[d][win*5 +: 5]; m_fnc[d] = fnc_s[d][win*8 +: 8];
                m_flr_last[d] = 1'b0; m_rr[d] = (win + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_payload(input int d);
        for (int i = 0; i < N; i++) begin
            set_s[d][i] = 1'($urandom);
            vec_s[d][i*5 +: 5] = 5'($urandom);
            fnc_s[d][i*8 +: 8] = 8'($urandom);
        end
        flr_fnc_s[d] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            en_s[d] = 1'b1; vld_s[d] = '1; flr_vld_s[d] = 1'b1; rand_payload(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got=%h expected=0", d, obs(d));
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        vld_s[0] = 4'b0010; set_s[0] = 4'b0010;
        vec_s[0][5 +: 5] = 5'h03; fnc_s[0][8 +: 8] = 8'h02;
        step(0);
        checks++;
        if (o_who[0] !== 1) begin errors++; $display("FAIL single_grant got=%0d expected=1", o_who[0]); end
        vld_s[0] = '0;
        checks++;
        if ({set_o[0], clr_o[0], vec_o[0], fnc_o[0]} !== {1'b1, 1'b0, 5'h03, 8'h02}) begin
            errors++;
            $display("FAIL single_pulse got=%b/%b/%h/%h expected=1/0/03/02",
                     set_o[0], clr_o[0], vec_o[0], fnc_o[0]);
        end
        repeat (4) step(0);
        checks++;
        if (cnt_a !== 4'd1) begin errors++; $display("FAIL single_count got=%0d expected=1", cnt_a); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int at[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        rand_payload(0);
        vld_s[0] = '1;
        for (int c = 0; c < 20; c++) begin
            step(0);
            if (o_who[0] != -1) begin order.push_back(o_who[0]); at.push_back(cyc); end
        end
        checks++;
        if (order.size() < 5) begin
            errors++;
            $display("FAIL rr_grants got=%0d expected>=5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order idx=%0d got=%0d expected=%0d", i, order[i], exp_order[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (at[i] - at[i-1] != 4) begin
                        errors++;
                        $display("FAIL rr_spacing idx=%0d got=%0d expected=4", i, at[i] - at[i-1]);
                    end
                end
            end
        end
        vld_s[0] = '0;
        repeat (4) step(0);
    endtask

    task automatic test_flr_contention();
        int order[$];
        int exp_order[4] = '{FLR_ID, 2, FLR_ID, 2};
        do_reset();
        rand_payload(0);
        vld_s[0] = 4'b0100; flr_vld_s[0] = 1'b1;
        for (int c = 0; c < 30 && order.size() < 4; c++) begin
            step(0);
            if (o_who[0] != -1) begin
                order.push_back(o_who[0]);
                flr_fnc_s[0] = 8'($urandom);
            end
        end
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL flr_grants got=%0d expected=4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL flr_order idx=%0d got=%0d expected=%0d", i, order[i], exp_order[i]);
                end
            end
        end
        vld_s[0] = '0; flr_vld_s[0] = 1'b0;
        repeat (4) step(0);
    endtask

    task automatic test_clear_gap0();
        int last;
        last = -1;
        do_reset();
        rand_payload(1);
        set_s[1] = '0;
        vld_s[1] = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            step(1);
            checks++;
            if (set_o[1] !== 1'b0) begin errors++; $display("FAIL clr_no_set got=%b expected=0", set_o[1]); end
            if (o_who[1] != -1) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL gap0_spacing got=%0d expected=2", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        vld_s[1] = '0;
        repeat (2) step(1);
    endtask

    task automatic test_en();
        int grants;
        grants = 0;
        do_reset();
        rand_payload(0);
        en_s[0] = 1'b0; vld_s[0] = '1; flr_vld_s[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(0);
            if (o_who[0] != -1) grants++;
        end
        en_s[0] = 1'b1;
        step(0);
        if (o_who[0] != -1) grants++;
        en_s[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(0);
            if (o_who[0] != -1) grants++;
        end
        checks++;
        if (grants != 1) begin errors++; $display("FAIL en_grants got=%0d expected=1", grants); end
        idle_inputs(0);
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        rand_payload(0);
        vld_s[0] = 4'b0100;
        step(0);
        checks++;
        if ((set_o[0] | clr_o[0]) !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pulse_present got=%b expected=1", set_o[0] | clr_o[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs(0) !== '0) begin errors++; $display("FAIL midrst_outputs got=%h expected=0", obs(0)); end
        @(negedge clk);
        model_reset();
        vld_s[0] = '1;
        rst_n = 1'b1;
        step(0);
        checks++;
        if (o_who[0] !== 0) begin errors++; $display("FAIL midrst_rr got=%0d expected=0", o_who[0]); end
        vld_s[0] = '0;
        repeat (4) step(0);
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        do_reset();
        rand_payload(0);
        vld_s[0] = '1;
        for (int c = 0; c < 200 && pulses < 17; c++) begin
            step(0);
            if (set_o[0] === 1'b1 || clr_o[0] === 1'b1 || fdv_o[0] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 17) begin
            errors++;
            $display("FAIL wrap_pulses got=%0d expected=17", pulses);
        end else begin
            checks++;
            if (cnt_a !== 4'd1) begin errors++; $display("FAIL wrap_count got=%0d expected=1", cnt_a); end
        end
        vld_s[0] = '0;
        repeat (4) step(0);
    endtask

    task automatic test_random(input int d, input int ncyc);
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld_s[d][i] && $urandom_range(3) == 0) begin
                    vld_s[d][i] = 1'b1;
                    set_s[d][i] = 1'($urandom);
                    vec_s[d][i*5 +: 5] = 5'($urandom);
                    fnc_s[d][i*8 +: 8] = 8'($urandom);
                end
            end
            if (!flr_vld_s[d] && $urandom_range(4) == 0) begin
                flr_vld_s[d] = 1'b1;
                flr_fnc_s[d] = 8'($urandom);
            end
            en_s[d] = ($urandom_range(7) != 0);
            step(d);
            if (g_who[d] == FLR_ID) flr_vld_s[d] = 1'b0;
            else if (g_who[d] >= 0) vld_s[d][g_who[d]] = 1'b0;
        end
        idle_inputs(d);
        repeat (4) step(d);
    endtask

    initial begin
        model_reset();
        idle_inputs(0);
        idle_inputs(1);
        test_reset();
        test_single();
        test_round_robin();
        test_flr_contention();
        test_clear_gap0();
        test_en();
        test_reset_mid_issue();
        test_wrap();
        test_random(0, 400);
        test_random(1, 400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/dma_usr_irq_flr_sched.md
Name: dma_usr_irq_flr_sched

Overview:
- Arbitrates and sequences user-interrupt set/clear requests and FLR-done notifications from several fabric requesters.
- Drives them onto the single DMA PCIe fabric input port (usr_irq_set/clr/vec/fnc, flr_done_vld/fnc).
- That port has no backpressure, so this block guarantees at most one event per issue slot, plus a programmable quiet gap between events.
- Sits between user logic and the QDMA fabric input interface (master side).

Parameters:
NUM_REQ, 4, number of interrupt requesters (2..8)
GAP_CYCLES, 2, idle cycles forced after every issued pulse (0..15)
CNT_W, 16, width of issued-event counter

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; low blocks new grants
req_vld  input  NUM_REQ  per-requester interrupt request valid
req_set  input  NUM_REQ  1 = set, 0 = clear, per requester
req_vec  input  NUM_REQ*5  interrupt vector, requester i at [5i+4:5i]
req_fnc  input  NUM_REQ*8  function number, requester i at [8i+7:8i]
req_rdy  output  NUM_REQ  one-hot accept strobe
flr_req_vld  input  1  FLR-done request valid
flr_req_fnc  input  8  FLR function number
flr_req_rdy  output  1  FLR accept strobe
usr_irq_set  output  1  fabric interrupt set pulse
usr_irq_clr  output  1  fabric interrupt clear pulse
usr_irq_vec  output  5  fabric interrupt vector
usr_irq_fnc  output  8  fabric interrupt function
flr_done_vld  output  1  fabric FLR-done pulse
flr_done_fnc  output  8  fabric FLR-done function
busy  output  1  high whenever the FSM is not in IDLE
issued_cnt  output  CNT_W  total events issued; wraps

Behaviour:
- Reset (async assert, sync deassert by user): all outputs 0, FSM=IDLE, rr_ptr=0, flr_last=0, gap counter=0, issued_cnt=0.
- FSM states IDLE -> ISSUE -> GAP -> IDLE. GAP is skipped (ISSUE->IDLE) when GAP_CYCLES=0.
- IDLE:
  - Arbitration is combinational. rdy strobes are asserted in IDLE only, only when en=1, one-hot across req_rdy and flr_req_rdy.
  - A handshake is vld&rdy in the same cycle. rdy never asserts without the matching vld.
- Priority:
  - FLR wins over interrupts unless flr_last=1 and any req_vld is high; in that case the interrupt path wins.
  - flr_last is set on an FLR grant and cleared on an interrupt grant. This guarantees alternation under contention.
- Interrupt round-robin:
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - On a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged otherwise.
- On grant at cycle T, the payload is registered. At T+1 (ISSUE) exactly one pulse is driven for exactly one cycle:
  - interrupt: usr_irq_set=req_set, usr_irq_clr=~req_set, with vec/fnc
  - FLR: flr_done_vld=1, with flr_done_fnc
  - usr_irq_set and usr_irq_clr are never both high.
- vec/fnc outputs are 0 in every cycle without a pulse.
- issued_cnt increments on each ISSUE cycle and wraps from all-ones to 0.
- GAP: counter loads GAP_CYCLES-1, decrements, and the FSM exits to IDLE at 0. No rdy is asserted during ISSUE or GAP.
- Throughput: one event per GAP_CYCLES+2 cycles.
- en deasserted mid-operation: an in-flight ISSUE/GAP completes. Only new grants are blocked.
- rst_n asserted mid-pulse: outputs clear immediately (async). A request already accepted is lost. Requesters must not depend on it.
- No request buffering: requesters hold vld and payload stable until rdy.

Test Plan:
- Single interrupt, GAP_CYCLES=2: req_vld[1]=1, set=1, vec=5'h03, fnc=8'h02 at T -> req_rdy[1]=1 at T; usr_irq_set=1, vec=3, fnc=2 at T+1 only; busy T+1..T+3; issued_cnt=1.
- Round-robin, all 4 requesters held valid -> grant order 0,1,2,3,0 with grants spaced 4 cycles apart; no rdy during ISSUE/GAP.
- FLR vs interrupt contention: flr_req_vld and req_vld[2] both held -> grants alternate FLR, irq2, FLR, irq2; flr_done_fnc matches flr_req_fnc on each FLR pulse.
- Clear path and GAP_CYCLES=0: req_set=0 on req 0 -> usr_irq_clr pulse 1 cycle, usr_irq_set stays 0; next grant occurs in the cycle right after ISSUE.
- en and reset: en=0 with requests pending -> no rdy, outputs 0. Drop en during GAP -> GAP completes, then no grant. Assert rst_n=0 during ISSUE -> pulse drops the same cycle, issued_cnt=0, rr_ptr=0.
- Counter wrap (CNT_W=4): 17 events -> issued_cnt=1.
